// File: rtl/booth_mac_32.sv
// Sequential radix-4 Booth multiply-accumulate: result = multiplicand*multiplier + addend.
// One Booth digit is retired per clock; start/busy/done handshake.
module booth_mac_32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH:0]     addend,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH:0]   result
);

  localparam int unsigned NDIG = WIDTH / 2 + 1;
  localparam int unsigned AW   = 2 * WIDTH + 3;
  localparam int unsigned CW   = $clog2(NDIG);
  localparam int unsigned YW   = WIDTH + 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [AW-1:0]   acc_q;
  logic [AW-1:0]   mcand_q;
  logic [YW-1:0]   y_q;
  logic [CW-1:0]   dig_q;
  logic [AW-1:0]   term;
  logic [AW-1:0]   acc_sum;
  logic            accept;
  logic            last_dig;

  assign accept   = start && (state_q != S_RUN);
  assign last_dig = (state_q == S_RUN) && (dig_q == CW'(NDIG - 1));
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_dig) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // y_q[2:0] is {y[2i+1], y[2i], y[2i-1]}; bit 0 starts as the implicit y[-1]=0.
  always_comb begin
    term = '0;
    unique case (y_q[2:0])
      3'b001, 3'b010: term = mcand_q;
      3'b011:         term = mcand_q << 1;
      3'b100:         term = -(mcand_q << 1);
      3'b101, 3'b110: term = -mcand_q;
      default:        term = '0;
    endcase
    acc_sum = acc_q + term;
  end

  // Two's-complement accumulator may dip negative mid-run; the final value is non-negative.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      y_q     <= '0;
      dig_q   <= '0;
      result  <= '0;
    end else if (accept) begin
      acc_q   <= AW'(addend);
      mcand_q <= AW'(multiplicand);
      y_q     <= {2'b00, multiplier, 1'b0};
      dig_q   <= '0;
    end else if (state_q == S_RUN) begin
      acc_q   <= acc_sum;
      mcand_q <= mcand_q << 2;
      y_q     <= y_q >> 2;
      dig_q   <= dig_q + 1'b1;
      if (last_dig) begin
        result <= acc_sum[2*WIDTH:0];
      end
    end
  end

endmodule
